// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared hex decoder, one digit lit at a time,
// all-off gap between digits, and shadow digit values that take effect only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL      = 1000,
    parameter int GAP        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx_i,
    input  logic [3:0]                    wr_data_i,
    input  logic                          wr_blank_i,
    output logic [6:0]                    seg_n_o,
    output logic [NUM_DIGITS-1:0]         dig_en_n_o,
    output logic                          frame_done_o
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_TC   = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_SHOW, S_GAP} state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d, idx_nxt;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        wrap;
    logic [NUM_DIGITS-1:0][3:0]  shadow_nib_q, active_nib_q;
    logic [NUM_DIGITS-1:0]       shadow_blank_q, active_blank_q;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       dig_q, dig_d;
    logic                        frame_done_q;
    logic                        wr_ready_q;
    logic                        wr_fire;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        wrap    = 1'b0;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                idx_d = '0;
                if (en_i) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == DWELL_TC) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        idx_d = idx_nxt;
                        wrap  = (idx_q == LAST_IDX);
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_TC) begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                    idx_d   = idx_nxt;
                    wrap    = (idx_q == LAST_IDX);
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
        if (!en_i) begin
            state_d = S_OFF;
            idx_d   = '0;
            cnt_d   = '0;
            wrap    = 1'b0;
        end
    end

    // Outputs gated by en_i so that dropping enable blanks the pins on the very next edge.
    always_comb begin
        seg_d = 7'h7F;
        dig_d = '1;
        if (state_q == S_SHOW && en_i) begin
            dig_d[idx_q] = 1'b0;
            if (!active_blank_q[idx_q]) seg_d = hex2seg(active_nib_q[idx_q]);
        end
    end

    assign wr_fire = wr_valid_i && wr_ready_q && (32'(wr_idx_i) < NUM_DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_OFF;
            idx_q          <= '0;
            cnt_q          <= '0;
            shadow_nib_q   <= '0;
            shadow_blank_q <= '1;
            active_nib_q   <= '0;
            active_blank_q <= '1;
            seg_q          <= 7'h7F;
            dig_q          <= '1;
            frame_done_q   <= 1'b0;
            wr_ready_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= wrap;
            wr_ready_q   <= ~wrap;
            if (wr_fire) begin
                shadow_nib_q[wr_idx_i]   <= wr_data_i;
                shadow_blank_q[wr_idx_i] <= wr_blank_i;
            end
            // Active copy follows the shadow while idle, and otherwise only at frame wrap.
            if (state_q == S_OFF || wrap) begin
                active_nib_q   <= shadow_nib_q;
                active_blank_q <= shadow_blank_q;
            end
        end
    end

    assign seg_n_o      = seg_q;
    assign dig_en_n_o   = dig_q;
    assign frame_done_o = frame_done_q;
    assign wr_ready_o   = wr_ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, DWELL=4, GAP=2.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_idx;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic [6:0] seg_n;
    logic [3:0] dig_en_n;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GAP(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_idx_i     (wr_idx),
        .wr_data_i    (wr_data),
        .wr_blank_i   (wr_blank),
        .seg_n_o      (seg_n),
        .dig_en_n_o   (dig_en_n),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [3:0] data, input logic blank);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        wr_blank = blank;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_dig(input logic [3:0] d, input string tag);
        int k = 0;
        while (dig_en_n !== d && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_dig"}, 32'(dig_en_n), 32'(d));
    endtask

    task automatic wait_fd(input string tag);
        int k = 0;
        while (frame_done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_fd"}, 32'(frame_done), 32'd1);
    endtask

    task automatic scan_digit(input logic [3:0] d, input logic [6:0] s, input string tag);
        wait_dig(d, tag);
        chk({tag, "_seg"}, 32'(seg_n), 32'(s));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_hold"}, {21'd0, dig_en_n, seg_n}, {21'd0, d, s});
        end
        tick();
        chk({tag, "_gap"}, {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        wr_blank = 1'b0;
        tick();
        tick();
        chk("rst_seg",   32'(seg_n),      32'h7F);
        chk("rst_dig",   32'(dig_en_n),   32'hF);
        chk("rst_fd",    32'(frame_done), 32'd0);
        chk("rst_ready", 32'(wr_ready),   32'd1);
        rst_n = 1'b1;
        tick();

        // 1: single digit 8, en off then on
        wr(2'd0, 4'h8, 1'b0);
        tick();
        chk("t1_off", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        en = 1'b1;
        tick();
        tick();
        chk("t1_on", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hE, 7'h00});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hE, 7'h00});
        end
        tick();
        chk("t1_gap0", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        tick();
        chk("t1_gap1", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        tick();
        chk("t1_blank1", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hD, 7'h7F});

        // 2: full frame 1,A,F,0
        en = 1'b0;
        tick();
        wr(2'd0, 4'h1, 1'b0);
        wr(2'd1, 4'hA, 1'b0);
        wr(2'd2, 4'hF, 1'b0);
        wr(2'd3, 4'h0, 1'b0);
        tick();
        en = 1'b1;
        scan_digit(4'hE, 7'h79, "t2_d0");
        scan_digit(4'hD, 7'h08, "t2_d1");
        scan_digit(4'hB, 7'h0E, "t2_d2");
        scan_digit(4'h7, 7'h40, "t2_d3");
        wait_fd("t2_first");
        chk("t2_ready_commit", 32'(wr_ready), 32'd0);
        k = 0;
        do begin
            tick();
            k++;
        end while (frame_done !== 1'b1 && k < 60);
        chk("t2_period", 32'(k), 32'd24);

        // 3: mid-frame write is deferred to the next frame
        wait_dig(4'hE, "t3_sync");
        wr(2'd1, 4'h1, 1'b0);
        wait_dig(4'hD, "t3_old");
        chk("t3_old_seg", 32'(seg_n), 32'h08);
        wait_fd("t3_commit");
        chk("t3_ready_lo", 32'(wr_ready), 32'd0);
        tick();
        chk("t3_ready_hi", 32'(wr_ready), 32'd1);
        chk("t3_fd_lo",    32'(frame_done), 32'd0);
        wait_dig(4'hD, "t3_new");
        chk("t3_new_seg", 32'(seg_n), 32'h79);

        // 4: blank digit 2
        wr(2'd2, 4'hF, 1'b1);
        wait_dig(4'hB, "t4_old");
        chk("t4_old_seg", 32'(seg_n), 32'h0E);
        wait_fd("t4_commit");
        wait_dig(4'hB, "t4_new");
        chk("t4_blank_seg", 32'(seg_n), 32'h7F);

        // 5: drop en while digit 2 lit, then restart at digit 0
        en = 1'b0;
        tick();
        chk("t5_off", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        tick();
        tick();
        chk("t5_still_off", 32'(dig_en_n), 32'hF);
        en = 1'b1;
        tick();
        tick();
        chk("t5_restart", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hE, 7'h79});

        // 6: reset mid-gap, then everything blank; back-to-back writes, last wins
        for (int i = 0; i < 4; i++) tick();
        chk("t6_in_gap", 32'(dig_en_n), 32'hF);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("t6_rst_out", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        chk("t6_rst_ready", 32'(wr_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        wr_valid = 1'b1;
        wr_idx   = 2'd3;
        wr_data  = 4'h2;
        wr_blank = 1'b0;
        tick();
        wr_data  = 4'h9;
        tick();
        wr_valid = 1'b0;
        en = 1'b1;
        tick();
        tick();
        chk("t6_blank0", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hE, 7'h7F});
        wait_dig(4'hB, "t6_d2");
        chk("t6_blank2", 32'(seg_n), 32'h7F);
        wait_dig(4'h7, "t6_d3");
        chk("t6_last_wins", 32'(seg_n), 32'h10);

        // asynchronous reset while a digit is lit
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_off", {21'd0, dig_en_n, seg_n}, {21'd0, 4'hF, 7'h7F});
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
